// File: rtl/lock_attempt_governor.sv
// Brute-force guard between the board keys and DigitalLock: counts failed entries
// and masks key input for an exponentially growing lockout after too many failures.
module lock_attempt_governor #(
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned BASE_LOCKOUT = 50000000,
  parameter int unsigned MAX_SHIFT    = 3,
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned FW = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1),
  localparam int unsigned LW = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           key_in,
  input  logic                 locked,
  input  logic                 error,
  output logic [3:0]           key_out,
  output logic                 lockout,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic [FW-1:0]        fail_count,
  output logic [LW-1:0]        level
);

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    BLOCK   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic                 error_q, locked_q;
  logic                 fail_ev, clear_ev;
  logic [3:0]           key_n;
  logic                 lockout_n;
  logic [CNT_WIDTH-1:0] remaining_n;
  logic [FW-1:0]        fail_n, fail_inc;
  logic [LW-1:0]        level_n;

  // Failures only count while the lock is armed; an unlock edge clears history.
  assign fail_ev  = error & ~error_q & locked;
  assign clear_ev = ~locked & locked_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= PASS;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
      key_out    <= 4'h0;
      lockout    <= 1'b0;
      remaining  <= '0;
      fail_count <= '0;
      level      <= '0;
    end else begin
      state      <= state_n;
      error_q    <= error;
      locked_q   <= locked;
      key_out    <= key_n;
      lockout    <= lockout_n;
      remaining  <= remaining_n;
      fail_count <= fail_n;
      level      <= level_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    fail_n      = fail_count;
    level_n     = level;
    fail_inc    = fail_count + FW'(1);

    case (state)
      PASS: begin
        if (fail_ev && !clear_ev) begin
          fail_n = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_n     = BLOCK;
            fail_n      = '0;
            remaining_n = CNT_WIDTH'(BASE_LOCKOUT) << level;
            level_n     = (level == LW'(MAX_SHIFT)) ? level : level + LW'(1);
          end
        end
      end
      BLOCK: begin
        if (remaining <= CNT_WIDTH'(1)) begin
          state_n     = RELEASE;
          remaining_n = '0;
        end else begin
          remaining_n = remaining - CNT_WIDTH'(1);
        end
      end
      RELEASE: begin
        if (key_in == 4'h0) state_n = PASS;
      end
      default: begin
        state_n     = PASS;
        remaining_n = '0;
      end
    endcase

    if (clear_ev) begin
      fail_n  = '0;
      level_n = '0;
    end

    // Gate on the next state so the edge that enters a lockout already masks keys.
    key_n     = (state_n == PASS) ? key_in : 4'h0;
    lockout_n = (state_n == BLOCK);
  end

endmodule

// File: tb/tb_lock_attempt_governor.sv
// Scoreboard bench for lock_attempt_governor: a time-based reference model predicts
// every clocked output; a monitor pops predictions and compares after each rising edge.
module tb_lock_attempt_governor;

  localparam int unsigned MF   = 2;
  localparam int unsigned BASE = 10;
  localparam int unsigned MS   = 2;
  localparam int unsigned CW   = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    key_in = 4'h0;
  logic          locked = 1'b0;
  logic          error = 1'b0;
  logic [3:0]    key_out;
  logic          lockout;
  logic [CW-1:0] remaining;
  logic [1:0]    fail_count;
  logic [1:0]    level;

  lock_attempt_governor #(
    .MAX_FAILS(MF), .BASE_LOCKOUT(BASE), .MAX_SHIFT(MS), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .key_in(key_in), .locked(locked), .error(error),
    .key_out(key_out), .lockout(lockout), .remaining(remaining),
    .fail_count(fail_count), .level(level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]    key;
    logic          lk;
    logic [CW-1:0] rem;
    logic [1:0]    fc;
    logic [1:0]    lv;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: lockout described by an absolute end cycle, not a down-counter.
  int   cyc = 0;
  bit   m_blocked, m_wait;
  int   m_end, m_fails, m_level;
  bit   m_pe, m_pl;

  task automatic model_step(input logic r, input logic [3:0] k, input logic l, input logic e);
    exp_t x;
    bit fail, clr;
    int dur;
    x = '0;
    if (r) begin
      m_blocked = 0; m_wait = 0; m_fails = 0; m_level = 0; m_pe = 0; m_pl = 0;
    end else begin
      fail = e && !m_pe && l;
      clr  = !l && m_pl;
      if (m_blocked) begin
        if (cyc < m_end) begin
          x.lk  = 1'b1;
          x.rem = CW'(m_end - cyc);
        end else begin
          m_blocked = 0;
          m_wait    = 1;
        end
      end else if (m_wait) begin
        if (k == 4'h0) m_wait = 0;
      end else begin
        x.key = k;
        if (fail && !clr) begin
          m_fails++;
          if (m_fails == MF) begin
            dur       = BASE * (2 ** m_level);
            m_fails   = 0;
            m_end     = cyc + dur;
            m_level   = (m_level < MS) ? m_level + 1 : m_level;
            m_blocked = 1;
            x.key     = 4'h0;
            x.lk      = 1'b1;
            x.rem     = CW'(dur);
          end
        end
      end
      if (clr) begin
        m_fails = 0;
        m_level = 0;
      end
      m_pe = e;
      m_pl = l;
      x.fc = 2'(m_fails);
      x.lv = 2'(m_level);
    end
    cyc++;
    last_exp = x;
    sb_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [3:0] k, input logic l, input logic e);
    @(negedge clock);
    reset = r; key_in = k; locked = l; error = e;
    model_step(r, k, l, e);
  endtask

  task automatic compare(input string name, input exp_t want);
    exp_t got;
    got = {key_out, lockout, remaining, fail_count, level};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got key=%h lockout=%b rem=%0d fc=%0d lv=%0d, want key=%h lockout=%b rem=%0d fc=%0d lv=%0d",
               name, $time, got.key, got.lk, got.rem, got.fc, got.lv,
               want.key, want.lk, want.rem, want.fc, want.lv);
    end
  endtask

  // Asynchronous reset must clear outputs before any clock edge arrives.
  task automatic async_reset(input logic [3:0] k);
    drive(1'b1, k, 1'b0, 1'b0);
    #1 compare("reset_immediate", '0);
  endtask

  task automatic fail_pulse(input logic [3:0] k);
    drive(1'b0, k, 1'b1, 1'b1);
    drive(1'b0, k, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n, input logic [3:0] k, input logic l);
    for (int i = 0; i < n; i++) drive(1'b0, k, l, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare("scoreboard", e);
      end
    end
  end

  initial begin : stimulus
    int guard;
    model_step(1'b1, 4'h0, 1'b0, 1'b0);
    void'(sb_q.pop_front());

    // Reset with keys applied, then forwarding after release of reset.
    for (int i = 0; i < 3; i++) async_reset(4'h5);
    idle(3, 4'h5, 1'b0);

    // Two failures trigger the first lockout while a key is held.
    idle(2, 4'hF, 1'b1);
    fail_pulse(4'hF);
    fail_pulse(4'hF);
    idle(14, 4'hF, 1'b1);

    // Press held across expiry stays masked until a full release.
    idle(4, 4'h1, 1'b1);
    idle(1, 4'h0, 1'b1);
    idle(2, 4'h1, 1'b1);
    idle(2, 4'h0, 1'b1);

    // Lockouts grow 20, 40, 40 then saturate.
    for (int n = 0; n < 3; n++) begin
      fail_pulse(4'h0);
      fail_pulse(4'h0);
      idle(45, 4'h0, 1'b1);
    end

    // Unlock clears failures and level; next lockout back to base length.
    fail_pulse(4'h3);
    idle(2, 4'h3, 1'b0);
    idle(2, 4'h0, 1'b1);
    fail_pulse(4'h0);
    fail_pulse(4'h0);
    idle(14, 4'h0, 1'b1);

    // Error while unlocked is ignored; error rise coinciding with unlock clears.
    idle(2, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    idle(2, 4'h0, 1'b1);
    fail_pulse(4'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    idle(2, 4'h0, 1'b0);

    // Reset in the middle of a lockout.
    idle(2, 4'h0, 1'b1);
    fail_pulse(4'h0);
    fail_pulse(4'h0);
    guard = 0;
    while (last_exp.rem != CW'(5) && guard < 100) begin
      idle(1, 4'h0, 1'b1);
      guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_bad++;
      $display("FAIL mid_lockout_wait: got no rem=5 within 100 cycles, want rem=5");
    end
    async_reset(4'h0);
    drive(1'b0, 4'h2, 1'b0, 1'b0);
    idle(2, 4'h2, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] k;
      logic l, e, r;
      k = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      l = ($urandom_range(49) == 0) ? ~locked : locked;
      e = ($urandom_range(3) == 0);
      r = ($urandom_range(499) == 0);
      if (r) async_reset(k);
      else drive(1'b0, k, l, e);
    end

    idle(2, 4'h0, 1'b0);
    @(posedge clock);
    #2;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending predictions, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
